// File: rtl/path_sequencer_if.sv
// Planner-to-sequencer path write bus.
`timescale 1ns/1ps
interface path_sequencer_if #(
  parameter int unsigned NODE_W = 5
) ();
  logic              path_wr;
  logic [NODE_W-1:0] path_node;
  logic              path_last;
  logic              path_ready;

  modport master (output path_wr, path_node, path_last, input path_ready);
  modport slave  (input path_wr, path_node, path_last, output path_ready);
endinterface

// File: rtl/path_sequencer.sv
// Path sequencer: buffers a planned node list and walks it one segment per
// physical node arrival, with node_flag bounce blanking after each segment.
`timescale 1ns/1ps
module path_sequencer #(
  parameter int unsigned NODE_W    = 5,
  parameter int unsigned MAX_LEN   = 32,
  parameter int unsigned BLANK_CYC = 3125
) (
  input  logic                clk_3125KHz,
  input  logic                rst_n,
  path_sequencer_if.slave     path_if,
  input  logic                path_clear,
  input  logic                CPU_start,
  input  logic                node_flag,
  output logic                node_changed,
  output logic [NODE_W-1:0]   curr_node,
  output logic [NODE_W-1:0]   next_node,
  output logic [4:0]          seg_idx,
  output logic [NODE_W-1:0]   realtime_pos,
  output logic                busy,
  output logic                done,
  output logic                err_ovf
);

  localparam int unsigned ADDR_W  = $clog2(MAX_LEN);
  localparam int unsigned IDX_W   = ADDR_W + 1;
  localparam int unsigned BLANK_W = $clog2(BLANK_CYC + 1);

  typedef enum logic [2:0] {IDLE, LOADED, ISSUE, WAIT_NODE, DONE} state_t;

  state_t              state;
  logic [NODE_W-1:0]   path_buf [MAX_LEN];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [IDX_W-1:0]    path_len;
  logic [IDX_W-1:0]    idx;
  logic [BLANK_W-1:0]  blank_cnt;
  logic                start_q, start_qq;
  logic                flag_q, flag_qq;
  logic                start_edge_c;
  logic                flag_edge_c;
  logic                wr_en_c;

  assign start_edge_c = start_q & ~start_qq;
  assign flag_edge_c  = flag_q & ~flag_qq;
  assign wr_en_c      = rst_n && (state == IDLE) && path_if.path_wr && !path_clear;

  // Path storage; contents are only meaningful up to path_len.
  always_ff @(posedge clk_3125KHz) begin
    if (wr_en_c) path_buf[wr_ptr] <= path_if.path_node;
  end

  // Control FSM with registered outputs and input edge history.
  always_ff @(posedge clk_3125KHz) begin
    if (!rst_n) begin
      state              <= IDLE;
      wr_ptr             <= '0;
      path_len           <= '0;
      idx                <= '0;
      blank_cnt          <= '0;
      start_q            <= 1'b0;
      start_qq           <= 1'b0;
      flag_q             <= 1'b0;
      flag_qq            <= 1'b0;
      node_changed       <= 1'b0;
      curr_node          <= '0;
      next_node          <= '0;
      seg_idx            <= '0;
      realtime_pos       <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      err_ovf            <= 1'b0;
      path_if.path_ready <= 1'b1;
    end else begin
      start_q      <= CPU_start;
      start_qq     <= start_q;
      flag_q       <= node_flag;
      flag_qq      <= flag_q;
      node_changed <= 1'b0;
      if (path_clear) begin
        state              <= IDLE;
        wr_ptr             <= '0;
        path_len           <= '0;
        idx                <= '0;
        blank_cnt          <= '0;
        curr_node          <= '0;
        next_node          <= '0;
        seg_idx            <= '0;
        busy               <= 1'b0;
        done               <= 1'b0;
        err_ovf            <= 1'b0;
        path_if.path_ready <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (path_if.path_wr) begin
              wr_ptr <= wr_ptr + 1'b1;
              if (path_if.path_last) begin
                path_len           <= IDX_W'(wr_ptr) + 1'b1;
                path_if.path_ready <= 1'b0;
                state              <= LOADED;
              end else if (wr_ptr == ADDR_W'(MAX_LEN - 1)) begin
                path_len           <= IDX_W'(MAX_LEN);
                err_ovf            <= 1'b1;
                path_if.path_ready <= 1'b0;
                state              <= LOADED;
              end
            end
          end
          LOADED: begin
            if (start_edge_c) begin
              idx <= '0;
              if (path_len < IDX_W'(2)) begin
                done  <= 1'b1;
                state <= DONE;
              end else begin
                state <= ISSUE;
              end
            end
          end
          ISSUE: begin
            curr_node    <= path_buf[idx[ADDR_W-1:0]];
            next_node    <= path_buf[ADDR_W'(idx + 1'b1)];
            seg_idx      <= 5'(idx);
            node_changed <= 1'b1;
            busy         <= 1'b1;
            blank_cnt    <= BLANK_W'(BLANK_CYC);
            state        <= WAIT_NODE;
          end
          WAIT_NODE: begin
            if (blank_cnt != '0) begin
              blank_cnt <= blank_cnt - 1'b1;
            end else if (flag_edge_c) begin
              realtime_pos <= next_node;
              if (idx + IDX_W'(2) == path_len) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= DONE;
              end else begin
                idx   <= idx + 1'b1;
                state <= ISSUE;
              end
            end
          end
          DONE: begin
            if (start_edge_c) begin
              done  <= 1'b0;
              idx   <= '0;
              state <= ISSUE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_path_sequencer.sv
// Scoreboard bench for path_sequencer: node_changed payloads are checked by a
// monitor against a queue filled by the stimulus process.
`timescale 1ns/1ps
module tb_path_sequencer;

  localparam int unsigned NODE_W    = 5;
  localparam int unsigned MAX_LEN   = 32;
  localparam int unsigned BLANK_CYC = 3125;

  logic clk_3125KHz = 1'b0;
  logic rst_n, path_clear, CPU_start, node_flag;
  logic node_changed, busy, done, err_ovf;
  logic [NODE_W-1:0] curr_node, next_node, realtime_pos;
  logic [4:0] seg_idx;

  path_sequencer_if #(.NODE_W(NODE_W)) pif ();

  path_sequencer #(.NODE_W(NODE_W), .MAX_LEN(MAX_LEN), .BLANK_CYC(BLANK_CYC)) dut (
    .clk_3125KHz (clk_3125KHz),
    .rst_n       (rst_n),
    .path_if     (pif),
    .path_clear  (path_clear),
    .CPU_start   (CPU_start),
    .node_flag   (node_flag),
    .node_changed(node_changed),
    .curr_node   (curr_node),
    .next_node   (next_node),
    .seg_idx     (seg_idx),
    .realtime_pos(realtime_pos),
    .busy        (busy),
    .done        (done),
    .err_ovf     (err_ovf)
  );

  always #5 clk_3125KHz = ~clk_3125KHz;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nc_count = 0;
  int last_nc = 0;
  logic prev_nc = 1'b0;
  logic [14:0] exp_q[$];

  always @(posedge clk_3125KHz) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every node_changed pulse must match the next queued segment.
  always @(negedge clk_3125KHz) begin
    logic [14:0] e;
    if (rst_n && node_changed) begin
      nc_count++;
      last_nc = cyc;
      check("node_changed back-to-back", 32'(prev_nc), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected node_changed: curr %0d next %0d seg %0d", curr_node, next_node, seg_idx);
      end else begin
        e = exp_q.pop_front();
        check("segment curr/next/seg", 32'({curr_node, next_node, seg_idx}), 32'(e));
      end
    end
    prev_nc = node_changed;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_3125KHz);
    #1;
  endtask

  task automatic write_node(input logic [NODE_W-1:0] n, input logic last);
    pif.path_wr   = 1'b1;
    pif.path_node = n;
    pif.path_last = last;
    step(1);
    pif.path_wr   = 1'b0;
    pif.path_last = 1'b0;
  endtask

  task automatic start_edge();
    CPU_start = 1'b1;
    step(3);
    CPU_start = 1'b0;
    step(2);
  endtask

  task automatic arrive();
    node_flag = 1'b1;
    step(3);
    node_flag = 1'b0;
    step(2);
  endtask

  task automatic push_seg(input logic [4:0] c, input logic [4:0] n, input logic [4:0] s);
    exp_q.push_back({c, n, s});
  endtask

  initial begin
    rst_n = 1'b0; path_clear = 1'b0; CPU_start = 1'b0; node_flag = 1'b0;
    pif.path_wr = 1'b0; pif.path_node = '0; pif.path_last = 1'b0;
    step(3);
    check("reset path_ready", 32'(pif.path_ready), 32'd1);
    check("reset outputs", 32'({node_changed, busy, done, err_ovf, curr_node, next_node, seg_idx, realtime_pos}), 32'd0);
    rst_n = 1'b1;
    step(2);

    // Four-node path 0,1,29,28
    write_node(5'd0, 1'b0);
    write_node(5'd1, 1'b0);
    write_node(5'd29, 1'b0);
    write_node(5'd28, 1'b1);
    check("loaded path_ready", 32'(pif.path_ready), 32'd0);
    push_seg(5'd0, 5'd1, 5'd0);
    start_edge();
    step(3);
    check("first pulse count", 32'(nc_count), 32'd1);
    check("busy after start", 32'(busy), 32'd1);
    step(3200);

    // First arrival with exact latency checks
    push_seg(5'd1, 5'd29, 5'd1);
    node_flag = 1'b1;
    step(1);
    check("rtpos before edge n+1", 32'(realtime_pos), 32'd0);
    step(1);
    check("rtpos at edge n+1", 32'(realtime_pos), 32'd1);
    step(1);
    check("node_changed after n+2", 32'(node_changed), 32'd1);
    node_flag = 1'b0;
    step(3200);
    push_seg(5'd29, 5'd28, 5'd2);
    arrive();
    step(3200);
    arrive();
    step(3);
    check("path done", 32'(done), 32'd1);
    check("path busy cleared", 32'(busy), 32'd0);
    check("final rtpos", 32'(realtime_pos), 32'd28);
    check("pulse total", 32'(nc_count), 32'd3);
    check("done holds curr/next", 32'({curr_node, next_node}), 32'({5'd29, 5'd28}));

    // Replay from DONE
    push_seg(5'd0, 5'd1, 5'd0);
    start_edge();
    check("replay done dropped", 32'(done), 32'd0);
    check("replay seg_idx", 32'(seg_idx), 32'd0);
    check("replay rtpos kept", 32'(realtime_pos), 32'd28);

    // Bounce during blanking is discarded
    while (cyc < last_nc + 100) step(1);
    node_flag = 1'b1; step(2); node_flag = 1'b0; step(2);
    node_flag = 1'b1; step(2); node_flag = 1'b0;
    while (cyc < last_nc + 3990) step(1);
    check("bounce no advance", 32'(nc_count), 32'd4);
    check("bounce rtpos", 32'(realtime_pos), 32'd28);
    push_seg(5'd1, 5'd29, 5'd1);
    arrive();
    step(3);
    check("late edge advance", 32'(seg_idx), 32'd1);
    check("late edge rtpos", 32'(realtime_pos), 32'd1);

    // Level held across end of blanking does not qualify
    while (cyc < last_nc + 100) step(1);
    node_flag = 1'b1;
    while (cyc < last_nc + 5000) step(1);
    node_flag = 1'b0;
    step(5);
    check("held level no advance", 32'(nc_count), 32'd5);

    // Clear with coincident node_flag edge
    path_clear = 1'b1;
    node_flag  = 1'b1;
    step(1);
    path_clear = 1'b0;
    step(3);
    node_flag = 1'b0;
    step(5);
    check("clear path_ready", 32'(pif.path_ready), 32'd1);
    check("clear outputs", 32'({busy, done, err_ovf, curr_node, next_node, seg_idx}), 32'd0);
    check("clear rtpos kept", 32'(realtime_pos), 32'd1);
    check("clear no pulse", 32'(nc_count), 32'd5);

    // Overflow: MAX_LEN writes without last, extra write dropped
    for (int i = 0; i < int'(MAX_LEN); i++) write_node(5'(i), 1'b0);
    check("overflow err_ovf", 32'(err_ovf), 32'd1);
    check("overflow path_ready", 32'(pif.path_ready), 32'd0);
    write_node(5'd9, 1'b1);
    check("extra write ready", 32'(pif.path_ready), 32'd0);
    push_seg(5'd0, 5'd1, 5'd0);
    start_edge();
    check("overflow pulse", 32'(nc_count), 32'd6);
    path_clear = 1'b1; step(1); path_clear = 1'b0; step(1);
    check("clear err_ovf", 32'(err_ovf), 32'd0);

    // Single-node path
    write_node(5'd7, 1'b1);
    step(2);
    CPU_start = 1'b1;
    step(1);
    check("single not done yet", 32'(done), 32'd0);
    step(1);
    check("single done timing", 32'(done), 32'd1);
    CPU_start = 1'b0;
    step(5);
    check("single no pulse", 32'(nc_count), 32'd6);
    check("single rtpos", 32'(realtime_pos), 32'd1);
    path_clear = 1'b1; step(1); path_clear = 1'b0; step(1);

    // Reset mid-traversal
    write_node(5'd3, 1'b0);
    write_node(5'd4, 1'b0);
    write_node(5'd6, 1'b1);
    push_seg(5'd3, 5'd4, 5'd0);
    start_edge();
    step(10);
    rst_n = 1'b0;
    step(1);
    check("midreset path_ready", 32'(pif.path_ready), 32'd1);
    check("midreset outputs", 32'({node_changed, busy, done, err_ovf, curr_node, next_node, seg_idx, realtime_pos}), 32'd0);
    rst_n = 1'b1;
    step(3);

    check("total pulses", 32'(nc_count), 32'd7);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/path_sequencer.md
Name: path_sequencer

Overview:
Sequences a planned node path for the bot's path-mapping/turn logic. Buffers a node list written by the planner CPU. After start, it walks the list one segment at a time. On each physical node arrival it presents curr_node/next_node and pulses node_changed so the turn-decision block computes the next turn. It also tracks real-time position, blanks node_flag bounce, and reports completion.

Parameters:
NODE_W, 5, node index width
MAX_LEN, 32, path buffer depth in entries (power of 2, ≥2)
BLANK_CYC, 3125, cycles after each node_changed during which node_flag is ignored (1 ms at 3.125 MHz)

Ports:
clk_3125KHz  in  1  system clock
rst_n  in  1  synchronous active-low reset
path_wr  in  1  planner write strobe
path_node  in  NODE_W  node index written with path_wr
path_last  in  1  marks path_node as final entry
path_ready  out  1  buffer accepts writes
path_clear  in  1  discard path, return to IDLE
CPU_start  in  1  level; rising edge starts or restarts traversal
node_flag  in  1  level from line follower, high while over a node
node_changed  out  1  one-cycle pulse, curr/next valid
curr_node  out  NODE_W  node being departed
next_node  out  NODE_W  node being approached
seg_idx  out  5  current segment index
realtime_pos  out  NODE_W  last node reached
busy  out  1  traversal in progress
done  out  1  level, final node reached
err_ovf  out  1  sticky, buffer overflowed

Behaviour:
- Reset (rst_n=0 at a clock edge): state IDLE, write ptr and path_len 0, every output 0 except path_ready=1; start-edge and node_flag history registers cleared. Reset mid-traversal aborts immediately.
- Edge detect: registered copies of CPU_start and node_flag. An edge means current=1 and previous=0.
- IDLE: path_ready=1. Each path_wr writes path_node at wr_ptr, then wr_ptr+1.
  - path_wr with path_last: path_len = wr_ptr+1, go LOADED.
  - Write at wr_ptr=MAX_LEN-1 without path_last: accepted, path_len=MAX_LEN, err_ovf=1, go LOADED.
- LOADED: path_ready=0, writes ignored. On a CPU_start edge, idx=0.
  - If path_len<2: go DONE with no node_changed.
  - Otherwise go ISSUE.
- ISSUE (one cycle):
  - curr_node=buf[idx], next_node=buf[idx+1], seg_idx=idx.
  - node_changed=1, busy=1, blank counter=BLANK_CYC, go WAIT_NODE.
- WAIT_NODE:
  - Blank counter decrements to 0 and saturates there.
  - A node_flag edge is qualified only when the counter is 0. Edges during blanking are discarded, not queued.
  - A level held high across the end of blanking does not qualify.
  - On a qualified edge: realtime_pos=next_node.
    - If idx+2==path_len: go DONE.
    - Otherwise idx+1, go ISSUE.
- Latency: the edge where node_flag is first sampled high (with blank=0) is edge n. realtime_pos updates at edge n+1; node_changed is high for the cycle after edge n+2.
- DONE: done=1, busy=0, curr/next hold.
  - A CPU_start edge clears done and replays the same path from idx 0 (ISSUE next).
  - realtime_pos is not reset on replay.
- path_clear (any state except during reset): next state IDLE. wr_ptr, path_len, done, busy, node_changed, seg_idx, curr/next all go to 0; err_ovf clears. realtime_pos is retained.
  - path_clear and path_wr in the same cycle: clear wins, write dropped.
  - path_clear and CPU_start edge in the same cycle: clear wins.
- CPU_start edges in ISSUE/WAIT_NODE are ignored.
- node_changed is never high in two consecutive cycles.
- Buffer is plain registers (MAX_LEN x NODE_W). idx arithmetic is unsigned, width log2(MAX_LEN)+1, so idx+2 cannot wrap.

Test Plan:
- Load 0,1,29,28 (last on 28), CPU_start edge → node_changed pulses with (curr,next)=(0,1); then on three spaced node_flag pulses, (1,29),(29,28); third arrival → done=1, realtime_pos=28, exactly 3 node_changed pulses total.
- node_flag bounce: two extra edges 100 cycles after a node_changed (BLANK_CYC=3125) → no advance; edge at 4000 cycles → advance; node_flag held high from cycle 100 to 5000 → no advance.
- Overflow: MAX_LEN=4, write 4 nodes without path_last → path_len=4, err_ovf=1, path_ready=0, a fifth write ignored.
- Single-node path (write 7 with last) + start → done=1 the cycle after LOADED processes start, node_changed never asserts, realtime_pos unchanged.
- Mid-traversal path_clear asserted with node_flag edge → IDLE, path_ready=1, no node_changed, realtime_pos keeps prior value; mid-traversal rst_n=0 → all outputs 0 after the edge.
- Replay: after DONE, CPU_start low then high → done drops, first pulse again (0,1), seg_idx=0.
